// File: rtl/dpram_ctrl_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter: requester ids,
// per-port return tags and round-robin scan arithmetic.
package dpram_ctrl_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int N_REQ_MAX  = 8;
    // Id width covers the largest supported requester count so one tag type fits all builds.
    localparam int ID_W       = $clog2(N_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } ret_tag_t;

    // Position of requester i in the scan that starts at p (0 = scanned first).
    function automatic int scan_dist(input int i, input int p, input int n);
        int d;
        d = i - p;
        return (d < 0) ? d + n : d;
    endfunction

    function automatic req_id_t wrap_inc(input req_id_t i, input int n);
        int j;
        j = int'(i) + 1;
        return (j >= n) ? '0 : req_id_t'(j);
    endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client-side bus of the RAM arbiter: flattened per-requester request fields
// plus grant and read-return signals.
interface dpram_arbiter_if
    import dpram_ctrl_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // req[i] is held with stable we/addr/wdata until gnt[i]; the access issues on the
    // clock edge where gnt[i] is high. rvalid[i] is a one-cycle pulse that cannot be stalled.
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [N_REQ*DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// Masked find-first-set starting at a rotating pointer: returns the set bit
// reached first when scanning ptr, ptr+1, ... mod N.
module rr_pick
    import dpram_ctrl_pkg::*;
#(
    parameter int N = N_REQ_DEF
) (
    input  logic [N-1:0] mask,
    input  req_id_t      ptr,
    output logic         found,
    output req_id_t      idx
);

    int best;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = N;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (scan_dist(i, int'(ptr), N) < best)) begin
                found = 1'b1;
                idx   = req_id_t'(i);
                best  = scan_dist(i, int'(ptr), N);
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one true dual-port RAM between N_REQ clients:
// up to two non-conflicting grants per cycle, read data routed back by tag.
module dpram_arbiter
    import dpram_ctrl_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wr_a,
    input  logic [DATA_W-1:0] ram_q_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_wr_b,
    input  logic [DATA_W-1:0] ram_q_b,
    output logic [15:0]       coll_cnt,
    output req_id_t           dbg_ptr
);

    req_id_t          ptr;
    ret_tag_t         tag_a, tag_b;
    logic             a_found, b_found;
    req_id_t          a_idx, b_idx;
    logic             a_we, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic [N_REQ-1:0] a_onehot, conflict, b_mask;
    logic             deferral;

    assign dbg_ptr = ptr;

    rr_pick #(.N(N_REQ)) u_pick_a (
        .mask  (bus.req),
        .ptr   (ptr),
        .found (a_found),
        .idx   (a_idx)
    );

    // Fields of the A winner, selected by loop to keep index widths exact.
    always_comb begin
        a_we     = 1'b0;
        a_addr   = '0;
        a_wdata  = '0;
        a_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (a_found && (a_idx == req_id_t'(i))) begin
                a_onehot[i] = 1'b1;
                a_we        = bus.we[i];
                a_addr      = bus.addr[i*ADDR_W +: ADDR_W];
                a_wdata     = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Same-address pairs are only safe on both ports when neither side writes.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < N_REQ; i++) begin
            conflict[i] = bus.req[i] && !a_onehot[i] && a_found
                       && (bus.addr[i*ADDR_W +: ADDR_W] == a_addr)
                       && (a_we || bus.we[i]);
        end
        b_mask = bus.req & ~a_onehot & ~conflict;
    end

    rr_pick #(.N(N_REQ)) u_pick_b (
        .mask  (b_mask),
        .ptr   (ptr),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (b_found && (b_idx == req_id_t'(i))) begin
                b_we    = bus.we[i];
                b_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                b_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A conflicting requester scanned before B (or with no B at all) would have been B.
    always_comb begin
        deferral = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (conflict[i] && (!b_found ||
                scan_dist(i, int'(ptr), N_REQ) < scan_dist(int'(b_idx), int'(ptr), N_REQ)))
                deferral = 1'b1;
        end
    end

    always_comb begin
        bus.gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.gnt[i] = (a_found && (a_idx == req_id_t'(i)))
                      || (b_found && (b_idx == req_id_t'(i)));
        end
    end

    always_comb begin
        ram_addr_a = a_found ? a_addr  : '0;
        ram_data_a = a_found ? a_wdata : '0;
        ram_wr_a   = a_found && a_we;
        ram_addr_b = b_found ? b_addr  : '0;
        ram_data_b = b_found ? b_wdata : '0;
        ram_wr_b   = b_found && b_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            tag_a    <= '0;
            tag_b    <= '0;
            coll_cnt <= '0;
        end else begin
            tag_a.valid <= a_found && !a_we;
            tag_a.id    <= a_idx;
            tag_b.valid <= b_found && !b_we;
            tag_b.id    <= b_idx;
            if (a_found)
                ptr <= wrap_inc(b_found ? b_idx : a_idx, N_REQ);
            if (deferral && (coll_cnt != 16'hFFFF))
                coll_cnt <= coll_cnt + 16'd1;
        end
    end

    // RAM q is already registered, so the return path only needs the registered tags.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_a.valid && (tag_a.id == req_id_t'(i))) begin
                bus.rvalid[i]                 = 1'b1;
                bus.rdata[i*DATA_W +: DATA_W] = ram_q_a;
            end else if (tag_b.valid && (tag_b.id == req_id_t'(i))) begin
                bus.rvalid[i]                 = 1'b1;
                bus.rdata[i*DATA_W +: DATA_W] = ram_q_b;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM and a
// scoreboard that matches every read return against hand-computed data.
module tb_dpram_arbiter;
    import dpram_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int W  = N + N*DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dpram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic          ram_wr_a, ram_wr_b;
    logic [15:0]   coll_cnt;
    req_id_t       dbg_ptr;

    dpram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_wr_a   (ram_wr_a),
        .ram_q_a    (ram_q_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_wr_b   (ram_wr_b),
        .ram_q_b    (ram_q_b),
        .coll_cnt   (coll_cnt),
        .dbg_ptr    (dbg_ptr)
    );

    // Behavioural 64x8 true dual-port RAM with registered q.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_wr_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [N*DW-1:0] rd(input int i, input logic [DW-1:0] d);
        logic [N*DW-1:0] v;
        v = '0;
        v[i*DW +: DW] = d;
        return v;
    endfunction

    // Monitor: every rvalid pulse must match the oldest expected return, on its due cycle.
    always @(negedge clk) begin
        if (|bus.rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_spurious", {bus.rvalid, bus.rdata}, '0);
            end else begin
                chk("rvalid_cycle", cyc, due_q[0]);
                chk("rdata", {bus.rvalid, bus.rdata}, exp_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            chk("rvalid_missing", {bus.rvalid, bus.rdata}, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    task automatic put(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.we[i]               = w;
        bus.addr[i*AW +: AW]    = a;
        bus.wdata[i*DW +: DW]   = d;
    endtask

    task automatic drop(input int i);
        bus.req[i] = 1'b0;
    endtask

    // One arbitration cycle: check gnt mid-cycle, queue any read return for the next cycle.
    task automatic grant_cycle(input string name, input logic [N-1:0] exp_gnt,
                               input logic [N-1:0] exp_rv, input logic [N*DW-1:0] exp_rd);
        @(negedge clk);
        chk(name, bus.gnt, exp_gnt);
        if (exp_rv != '0) begin
            exp_q.push_back({exp_rv, exp_rd});
            due_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", bus.gnt, '0);
        chk("rst_rvalid", bus.rvalid, '0);
        chk("rst_wr_a", ram_wr_a, 1'b0);
        chk("rst_wr_b", ram_wr_b, 1'b0);
        chk("rst_coll", coll_cnt, 16'd0);
        chk("rst_ptr", dbg_ptr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read of the same address
        put(0, 1'b1, 6'd5, 8'hA5);
        grant_cycle("t2_wr_gnt", 4'b0001, '0, '0);
        drop(0);
        put(2, 1'b0, 6'd5, 8'h00);
        grant_cycle("t2_rd_gnt", 4'b0100, 4'b0100, rd(2, 8'hA5));
        drop(2);

        // Two writers on one address: second is deferred, then wins
        put(0, 1'b1, 6'd9, 8'h11);
        put(1, 1'b1, 6'd9, 8'h99);
        grant_cycle("t3_gnt_req0", 4'b0001, '0, '0);
        drop(0);
        grant_cycle("t3_gnt_req1", 4'b0010, '0, '0);
        drop(1);
        put(3, 1'b0, 6'd9, 8'h00);
        grant_cycle("t3_rd_gnt", 4'b1000, 4'b1000, rd(3, 8'h99));
        drop(3);
        chk("t3_coll", coll_cnt, 16'd1);
        chk("t3_ptr", dbg_ptr, 0);

        // Two reads of one address share a cycle
        put(2, 1'b1, 6'd12, 8'h3C);
        grant_cycle("t4_wr_gnt", 4'b0100, '0, '0);
        drop(2);
        put(1, 1'b0, 6'd12, 8'h00);
        put(3, 1'b0, 6'd12, 8'h00);
        grant_cycle("t4_both_gnt", 4'b1010, 4'b1010, rd(1, 8'h3C) | rd(3, 8'h3C));
        drop(1);
        drop(3);
        chk("t4_coll", coll_cnt, 16'd1);
        chk("t4_ptr", dbg_ptr, 2);

        // Conflicting candidate skipped, later requester takes port B
        put(2, 1'b1, 6'd20, 8'h5A);
        put(3, 1'b0, 6'd20, 8'h00);
        put(0, 1'b0, 6'd5, 8'h00);
        grant_cycle("skip_gnt", 4'b0101, 4'b0001, rd(0, 8'hA5));
        drop(2);
        drop(0);
        chk("skip_coll", coll_cnt, 16'd2);
        grant_cycle("raw_gnt", 4'b1000, 4'b1000, rd(3, 8'h5A));
        drop(3);

        // All four requesting continuously
        put(0, 1'b0, 6'd5, 8'h00);
        put(1, 1'b0, 6'd9, 8'h00);
        put(2, 1'b0, 6'd12, 8'h00);
        put(3, 1'b0, 6'd20, 8'h00);
        for (int k = 0; k < 6; k++) begin
            chk("t5_ptr", dbg_ptr, (k % 2 == 0) ? 0 : 2);
            if (k % 2 == 0)
                grant_cycle("t5_gnt_lo", 4'b0011, 4'b0011, rd(0, 8'hA5) | rd(1, 8'h99));
            else
                grant_cycle("t5_gnt_hi", 4'b1100, 4'b1100, rd(2, 8'h3C) | rd(3, 8'h5A));
        end
        bus.req = '0;
        chk("t5_coll", coll_cnt, 16'd2);

        // Reset right after a read grant drops the read and the pointer
        put(2, 1'b0, 6'd12, 8'h00);
        grant_cycle("t6_rd_gnt", 4'b0100, '0, '0);
        drop(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rvalid", bus.rvalid, '0);
        chk("t6_ptr", dbg_ptr, 0);
        chk("t6_coll", coll_cnt, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        put(1, 1'b1, 6'd7, 8'h77);
        put(3, 1'b1, 6'd7, 8'h33);
        grant_cycle("t6_lowest_gnt", 4'b0010, '0, '0);
        drop(1);
        grant_cycle("t6_next_gnt", 4'b1000, '0, '0);
        drop(3);
        chk("t6_coll_after", coll_cnt, 16'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
